// File: rtl/buffer_register_duplex.sv
// Duplex buffer register: two sense/transfer channel engines (even/odd modules) with
// odd-parity checking and an optional cross-channel compare.
module buffer_register_duplex #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MODULES   = 8,
    parameter int unsigned SENSE_CYC = 2,
    parameter bit          DUPLEX    = 1'b1
) (
    input  logic                     v1,
    input  logic                     rstn,
    input  logic [MODULES*WIDTH-1:0] sa,
    input  logic                     rd_a,
    input  logic                     rd_b,
    input  logic                     sbrx_a,
    input  logic                     sbrx_b,
    input  logic [WIDTH-2:0]         tr_a,
    input  logic [WIDTH-2:0]         tr_b,
    input  logic                     cbr_an,
    input  logic                     cbr_bn,
    output logic [WIDTH-1:0]         bra,
    output logic [WIDTH-1:0]         brb,
    output logic                     busy_a,
    output logic                     busy_b,
    output logic                     valid_a,
    output logic                     valid_b,
    output logic                     par_err_a,
    output logic                     par_err_b,
    output logic                     miscompare
);

    localparam int unsigned DW = WIDTH - 1;
    localparam int unsigned CW = (SENSE_CYC > 1) ? $clog2(SENSE_CYC) : 1;

    typedef enum logic [1:0] {StIdle, StSense, StCheck} state_e;

    logic [1:0]       rd;
    logic [1:0]       sbrx;
    logic [1:0]       cbrn;
    logic [DW-1:0]    tr       [2];
    logic [WIDTH-1:0] sense_or [2];

    logic [1:0][WIDTH-1:0] br_w;
    logic [1:0]            busy_w;
    logic [1:0]            valid_w;
    logic [1:0]            perr_w;

    // In duplex mode channel B is slaved entirely to channel A's controls.
    always_comb begin
        rd[0]   = rd_a;
        sbrx[0] = sbrx_a;
        cbrn[0] = cbr_an;
        tr[0]   = tr_a;
        rd[1]   = DUPLEX ? rd_a   : rd_b;
        sbrx[1] = DUPLEX ? sbrx_a : sbrx_b;
        cbrn[1] = DUPLEX ? cbr_an : cbr_bn;
        tr[1]   = DUPLEX ? tr_a   : tr_b;
    end

    // Channel A sees even modules, channel B odd modules.
    always_comb begin
        sense_or[0] = '0;
        sense_or[1] = '0;
        for (int m = 0; m < int'(MODULES / 2); m++) begin
            sense_or[0] = sense_or[0] | sa[(2*m)*WIDTH +: WIDTH];
            sense_or[1] = sense_or[1] | sa[(2*m+1)*WIDTH +: WIDTH];
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_ch
        state_e           state_q, state_d;
        logic [CW-1:0]    cnt_q, cnt_d;
        logic [WIDTH-1:0] br_q, br_d;
        logic             valid_q, valid_d;
        logic             perr_q, perr_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            br_d    = br_q;
            valid_d = valid_q;
            perr_d  = perr_q;
            unique case (state_q)
                StIdle: begin
                    if (!cbrn[c]) begin
                        br_d    = '0;
                        valid_d = 1'b0;
                        perr_d  = 1'b0;
                    end else if (rd[c]) begin
                        br_d    = '0;
                        valid_d = 1'b0;
                        perr_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = StSense;
                    end else if (sbrx[c]) begin
                        br_d    = {~^tr[c], tr[c]};
                        valid_d = 1'b1;
                        perr_d  = 1'b0;
                    end
                end
                StSense: begin
                    if (!cbrn[c]) begin
                        br_d    = '0;
                        valid_d = 1'b0;
                        perr_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        br_d = br_q | sense_or[c];
                        if (cnt_q == CW'(SENSE_CYC - 1)) begin
                            state_d = StCheck;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                StCheck: begin
                    if (!cbrn[c]) begin
                        br_d    = '0;
                        valid_d = 1'b0;
                        perr_d  = 1'b0;
                    end else begin
                        valid_d = 1'b1;
                        // Odd parity: an even count of ones is an error.
                        perr_d  = ~^br_q;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end

        always_ff @(posedge v1 or negedge rstn) begin
            if (!rstn) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                br_q    <= '0;
                valid_q <= 1'b0;
                perr_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                br_q    <= br_d;
                valid_q <= valid_d;
                perr_q  <= perr_d;
            end
        end

        assign br_w[c]    = br_q;
        assign busy_w[c]  = (state_q != StIdle);
        assign valid_w[c] = valid_q;
        assign perr_w[c]  = perr_q;
    end

    always_ff @(posedge v1 or negedge rstn) begin
        if (!rstn) begin
            miscompare <= 1'b0;
        end else begin
            miscompare <= DUPLEX & valid_w[0] & valid_w[1] & (br_w[0] != br_w[1]);
        end
    end

    assign bra       = br_w[0];
    assign brb       = br_w[1];
    assign busy_a    = busy_w[0];
    assign busy_b    = busy_w[1];
    assign valid_a   = valid_w[0];
    assign valid_b   = valid_w[1];
    assign par_err_a = perr_w[0];
    assign par_err_b = perr_w[1];

endmodule

// File: doc/buffer_register_duplex.md
BUFFER_REGISTER_DUPLEX -- requirements
Module: buffer_register_duplex

Interface
REQ-001 SHALL have parameter WIDTH, default 4, register width; bit WIDTH-1 is parity, bits WIDTH-2..0 are data (DW = WIDTH-1).
REQ-002 SHALL have parameter MODULES, default 8, number of memory modules feeding sense inputs (even value, >= 2).
REQ-003 SHALL have parameter SENSE_CYC, default 2, number of sense-accumulate cycles per read (>= 1).
REQ-004 SHALL have parameter DUPLEX, default 1: 1 = channel B slaved to channel A controls with compare enabled; 0 = independent channels, compare disabled.
REQ-005 SHALL have port v1 (input, 1): the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rstn (input, 1): asynchronous, active-low reset.
REQ-007 SHALL have port sa (input, MODULES*WIDTH): sense-amp outputs; module m occupies bits [m*WIDTH +: WIDTH].
REQ-008 SHALL have ports rd_a, rd_b (input, 1): start a memory read sequence on the channel.
REQ-009 SHALL have ports sbrx_a, sbrx_b (input, 1): load the buffer from the transfer register.
REQ-010 SHALL have ports tr_a, tr_b (input, DW): transfer-register data.
REQ-011 SHALL have ports cbr_an, cbr_bn (input, 1): active-low clear of the buffer.
REQ-012 SHALL have ports bra, brb (output, WIDTH): buffer register contents.
REQ-013 SHALL have ports busy_a, busy_b, valid_a, valid_b, par_err_a, par_err_b, miscompare (output, 1 each).

Function
REQ-014 SHALL have two identical channel engines, each with states IDLE, SENSE and CHECK; A sums even modules (0,2,4..), B sums odd modules (1,3,5..).
REQ-015 SHALL, in IDLE, apply priority cbr_xn low > rd_x > sbrx_x.
REQ-016 SHALL, on cbr_xn low in IDLE, set br_x=0, valid_x=0 and par_err_x=0 at the next edge.
REQ-017 SHALL, on rd_x in IDLE, set br_x=0, valid_x=0 and par_err_x=0, then enter SENSE.
REQ-018 SHALL, in SENSE, OR into br_x the bitwise OR of its channel's module words every edge for exactly SENSE_CYC edges, then enter CHECK.
REQ-019 SHALL, on the CHECK edge, set valid_x=1, set par_err_x=1 iff the count of ones in br_x is even (odd parity), and return to IDLE.
REQ-020 SHALL have read latency SENSE_CYC+2 edges from the edge sampling rd_x to valid_x=1.
REQ-021 SHALL, on sbrx_x in IDLE, load br_x = {~^tr_x, tr_x} with valid_x=1 and par_err_x=0 in 1 edge.
REQ-022 SHALL hold busy_x=1 exactly while in SENSE or CHECK.
REQ-023 SHALL ignore rd_x and sbrx_x while busy.
REQ-024 SHALL, when cbr_xn is low in SENSE or CHECK, abort to IDLE with br_x=0 and valid_x=0 at the next edge.
REQ-025 SHALL hold br_x, valid_x and par_err_x in IDLE when no control is active.
REQ-026 SHALL, when DUPLEX=1, drive channel B from rd_a, sbrx_a, tr_a and cbr_an, ignoring rd_b, sbrx_b, tr_b and cbr_bn.
REQ-027 SHALL register miscompare each edge = DUPLEX & valid_a & valid_b & (bra != brb), asserting one edge after both valids are high.
REQ-028 SHALL force miscompare to 0 when DUPLEX=0.

Reset
REQ-029 SHALL, with rstn low, immediately set both engines to IDLE and drive bra, brb, busy_*, valid_*, par_err_* and miscompare to 0, independent of v1.
REQ-030 SHALL, when rstn deasserts mid-read, resume in IDLE with no pending read.

Verification
REQ-031 SHALL cover reset: rstn low at any time -> all outputs 0 asynchronously.
REQ-032 SHALL cover transfer load: DUPLEX=0, sbrx_a with tr_a=3'b101 -> next edge bra=4'b1101, valid_a=1, par_err_a=0.
REQ-033 SHALL cover a clean read: DUPLEX=0, SENSE_CYC=2, rd_a with module 2 driving 4'b1011 during SENSE -> busy_a high for 3 edges, bra=4'b1011, valid_a=1 on edge 4, par_err_a=0.
REQ-034 SHALL cover a parity fault: same read with module 0 driving 4'b0110 -> bra=4'b0110, par_err_a=1.
REQ-035 SHALL cover a duplex miscompare: DUPLEX=1, rd_a, module 0 = 4'b1011, module 1 = 4'b1101 -> both valids on edge 4, miscompare=1 on edge 5; equal words -> miscompare=0.
REQ-036 SHALL cover an abort: cbr_an low during SENSE -> next edge bra=0, busy_a=0, valid_a=0; a rd_a issued while busy -> ignored.
